// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width; never narrower than one bit so W=1 still has a counter.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/my_full_subtractor.sv
// One-bit full-subtractor cell: diff = a - b - borrow_in, combinational.
module my_full_subtractor (
  output logic diff,
  output logic borrow_out,
  input  logic a,
  input  logic b,
  input  logic borrow_in
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (diff = a - b), LSB first, start/done handshake.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepted edge
// RUN   | one bit per clock through the full-subtractor cell
// DONE  | one-cycle done pulse, results valid and held
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic         overflow
`endif
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state, state_nxt;
  logic [W-1:0]  a_sh, b_sh;
  logic [CW-1:0] count;
  logic          bor;
  logic          d, bo, last;

  my_full_subtractor u_cell (
    .diff      (d),
    .borrow_out(bo),
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .borrow_in (bor)
  );

  assign last = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      bor      <= 1'b0;
      count    <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          bor   <= 1'b0;
          count <= '0;
          diff  <= '0;
        end
        RUN: begin
          diff  <= (diff >> 1) | (W'(d) << (W - 1));
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          bor   <= bo;
          count <= count + 1'b1;
          if (last) begin
            borrow   <= bo;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // On the last bit a_sh[0]/b_sh[0] are the captured operand MSBs.
            overflow <= (a_sh[0] ^ b_sh[0]) & (d ^ a_sh[0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial W-bit subtractor computing diff = a - b, LSB first, one bit per clock. It reuses a one-bit full-subtractor cell, the borrow-chain counterpart of the full adder cell. A start/done handshake lets a small controller or bench issue back-to-back subtractions. Intended as the sequential, area-minimal arithmetic companion to the combinational adder cells.

Parameters:
W, 8, operand and result width in bits; legal range W >= 1

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  W  minuend; captured on the accepted start edge only
b  input  W  subtrahend; captured on the accepted start edge only
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when diff/borrow become valid
diff  output  W  a - b modulo 2^W; held from done until the next accepted start
borrow  output  1  final borrow-out; 1 iff a < b (unsigned); held like diff

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow=0, count=0, internal borrow=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1, load a_sh<=a, b_sh<=b, bor<=0, count<=0, clear diff shift register; go to RUN.
  - RUN: each cycle the cell computes d = a_sh[0]^b_sh[0]^bor and bo = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&bor).
    - d shifts into diff at the MSB; diff shifts right.
    - a_sh and b_sh shift right; bor<=bo; count++.
    - When count==W-1 (last bit), set borrow<=bo and go to DONE.
  - DONE: done=1 for exactly this cycle; go to IDLE unconditionally.
- Latency: start accepted at edge k; RUN occupies edges k+1..k+W; done=1 in the cycle following edge k+W. Total W+1 cycles.
- Throughput: one operation per W+2 cycles (start may be re-asserted in the cycle after done).
- busy=1 exactly during RUN. start is ignored in RUN and DONE; no queueing.
- a and b may change freely after the start edge; only the captured values are used.
- diff and borrow are registered outputs.
  - During RUN, diff holds the partial shift contents and is not valid.
  - After done, both remain stable until the next accepted start.
- W=1: RUN lasts one cycle. The counter width is max(1,$clog2(W)).
- Reset asserted mid-RUN or in DONE: the operation is aborted, all values return to reset, and no done pulse is produced.
- Simultaneous reset and start: reset wins; start is not accepted.

Optional Feature:
- Macro SERIAL_SUB_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit), the signed two's-complement overflow.
  - overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the captured operand MSBs.
  - Registered at the last RUN edge alongside borrow; reset to 0; held like diff.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package serial_arith_pkg holds:
  - the state typedef (IDLE, RUN, DONE) as a 2-bit enum;
  - the helper function for counter width.
- One sub-module, my_full_subtractor(diff, borrow_out, a, b, borrow_in), is purely combinational. Port order mirrors the existing full adder cell. It gets its own exhaustive 8-row truth-table test.

Test Plan:
- W=8, a=5, b=3, pulse start -> busy high 8 cycles; done pulses exactly 9 cycles after the start edge; diff=0x02, borrow=0.
- a=3, b=5 -> diff=0xFE, borrow=1. Then a=0, b=0 -> diff=0x00, borrow=0. Results held stable for 20 idle cycles after done.
- With SERIAL_SUB_OVERFLOW_EN: a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1. a=0x10, b=0x01 -> diff=0x0F, overflow=0.
- start held high continuously, and a/b changed during RUN -> ops back-to-back every 10 cycles; each result matches the operands captured at its own start edge.
- reset asserted at the 4th RUN cycle with a=0xFF, b=0x01 -> next cycle busy=0, diff=0, borrow=0, no done pulse. New op a=0x20, b=0x21 -> diff=0xFF, borrow=1.
- W=1 instance, all 4 operand pairs -> done 2 cycles after start. 0-1 gives diff=1, borrow=1; 1-0 gives diff=1, borrow=0; 0-0 and 1-1 give diff=0, borrow=0.
